// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Provides the FSM state encoding and the leading-zero helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int unsigned BCD_BASE   = 10;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4;

    // The ones digit never counts as a leading zero.
    function automatic logic [1:0] lz_count(input logic [BCD_W*BCD_DIGITS-1:0] b);
        logic [1:0] n;
        n = 2'd0;
        if (b[11:8] == 4'd0 && b[7:4] == 4'd0) n = 2'd2;
        else if (b[11:8] == 4'd0)              n = 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle between the binary producer, the converter
// and the BCD consumer.
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [1:0]            out_lz;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_lz
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_lz
    );
endinterface

// File: rtl/bin2bcd_seq_divider.sv
// Combinational unsigned restoring divider: q = x / y, r = x % y.
// Division by zero yields q = all ones and r = x truncated, never X.
module divider #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 4,
    parameter int unsigned QW = 8,
    parameter int unsigned RW = 5
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [QW-1:0] q,
    output logic [RW-1:0] r
);

    logic [XW-1:0] quo;
    logic [YW:0]   rem;

    always_comb begin
        quo = '0;
        rem = '0;
        // Shift in one dividend bit per step, MSB first; rem stays below 2*y.
        for (int unsigned i = 0; i < XW; i++) begin
            rem = {rem[YW-1:0], x[XW-1-i]};
            if (rem >= {1'b0, y}) begin
                rem            = rem - {1'b0, y};
                quo[XW-1-i]    = 1'b1;
            end
        end
    end

    assign q = QW'(quo);
    assign r = RW'(rem);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one divide-by-10 per clock, digits
// shifted in from the top so the first remainder lands in the ones slot.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  io
);

    localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
    localparam int unsigned BCD_TOT = BCD_W * DIGITS;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     work;
    logic [BCD_TOT-1:0]   bcd;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     div_q;
    logic [4:0]           div_r;
    logic                 div_r_msb_unused;

    divider #(
        .XW (WIDTH),
        .YW (BCD_W),
        .QW (WIDTH),
        .RW (5)
    ) u_div (
        .x (work),
        .y (BCD_W'(BCD_BASE)),
        .q (div_q),
        .r (div_r)
    );

    // Remainder of a divide by 10 is always < 10, so the top bit carries nothing.
    assign div_r_msb_unused = div_r[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.out_bcd   = '0;
        io.out_lz    = '0;
        case (state)
            IDLE: begin
                io.in_ready = ~rst;
                if (io.in_valid) state_nx = CONV;
            end
            CONV: begin
                if (cnt == CNT_W'(DIGITS - 1)) state_nx = DONE;
            end
            DONE: begin
                io.out_valid = 1'b1;
                io.out_bcd   = bcd;
                io.out_lz    = lz_count(bcd);
                if (io.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            bcd  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        work <= io.in_data;
                        bcd  <= '0;
                        cnt  <= '0;
                    end
                end
                CONV: begin
                    work <= div_q;
                    bcd  <= {div_r[BCD_W-1:0], bcd[BCD_TOT-1:BCD_W]};
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) io ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    function automatic logic [11:0] ref_bcd(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [1:0] ref_lz(input int unsigned v);
        if (v < 10)  return 2'd2;
        if (v < 100) return 2'd1;
        return 2'd0;
    endfunction

    // Background invariants: remainder top bit during conversion, work drained at result.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (io.in_ready === 1'b0 && io.out_valid === 1'b0) begin
                checks++;
                if (dut.div_r[4] !== 1'b0) begin
                    errors++;
                    $display("FAIL r4_zero got %b exp 0 at %0t", dut.div_r[4], $time);
                end
            end
            if (io.out_valid === 1'b1) begin
                checks++;
                if (dut.work !== 8'd0) begin
                    errors++;
                    $display("FAIL work_drained got %0d exp 0 at %0t", dut.work, $time);
                end
            end
        end
    end

    task automatic send(input logic [7:0] v, output bit ok);
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data  = v;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (io.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
        io.in_data  = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit saw_ready, output bit ok);
        lat = 0;
        saw_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (io.in_ready !== 1'b0) saw_ready = 1'b1;
            if (io.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.in_valid  = 1'b0;
        io.in_data   = 8'd0;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0 || io.out_bcd !== 12'h000 || io.out_lz !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b bcd=%h lz=%0d exp 0 0 000 0",
                     io.in_ready, io.out_valid, io.out_bcd, io.out_lz);
        end
        checks++;
        if (dut.work !== 8'd0 || dut.cnt !== '0 || dut.bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_internal got work=%0d cnt=%0d bcd=%h exp 0 0 000",
                     dut.work, dut.cnt, dut.bcd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", io.in_ready);
        end
    endtask

    task automatic test_value(input logic [7:0] v);
        bit ok_s, ok_v, saw;
        int lat;
        send(v, ok_s);
        wait_valid(lat, saw, ok_v);
        checks++;
        if (!ok_s || !ok_v || lat != 3) begin
            errors++;
            $display("FAIL v%0d_latency got %0d (acc=%b vld=%b) exp 3", v, lat, ok_s, ok_v);
        end
        checks++;
        if (io.out_bcd !== ref_bcd(v) || io.out_lz !== ref_lz(v)) begin
            errors++;
            $display("FAIL v%0d_result got bcd=%h lz=%0d exp bcd=%h lz=%0d",
                     v, io.out_bcd, io.out_lz, ref_bcd(v), ref_lz(v));
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL v%0d_ready_busy got 1 exp 0", v);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL v%0d_after_xfer got vld=%b rdy=%b exp 0 1", v, io.out_valid, io.in_ready);
        end
    endtask

    task automatic test_boundaries();
        test_value(8'd0);
        test_value(8'd255);
        test_value(8'd100);
        test_value(8'd9);
        test_value(8'd10);
    endtask

    task automatic test_stall();
        bit ok_s, ok_v, saw;
        int lat;
        int bad = 0;
        send(8'd137, ok_s);
        wait_valid(lat, saw, ok_v);
        checks++;
        if (!ok_s || !ok_v || lat != 3) begin
            errors++;
            $display("FAIL stall_latency got %0d exp 3", lat);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (io.out_valid !== 1'b1 || io.out_bcd !== 12'h137 || io.out_lz !== 2'd0 || io.in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles exp 0 (vld=%b bcd=%h lz=%0d rdy=%b)",
                     bad, io.out_valid, io.out_bcd, io.out_lz, io.in_ready);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b exp 0 1", io.out_valid, io.in_ready);
        end
        @(negedge clk);
        checks++;
        if (io.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_xfer got vld=%b exp 0", io.out_valid);
        end
    endtask

    task automatic test_abort();
        bit ok_s;
        int seen = 0;
        send(8'd201, ok_s);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!ok_s || io.out_valid !== 1'b0 || io.in_ready !== 1'b0 || io.out_bcd !== 12'h000) begin
            errors++;
            $display("FAIL abort_async got acc=%b vld=%b rdy=%b bcd=%h exp 1 0 0 000",
                     ok_s, io.out_valid, io.in_ready, io.out_bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (io.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || io.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_result got %0d valid cycles rdy=%b exp 0 1", seen, io.in_ready);
        end
        test_value(8'd42);
    endtask

    task automatic test_back_to_back();
        bit ok_s, ok_v, saw, xfer;
        int lat;
        int bad;
        logic [11:0] held;
        for (int v = 0; v < 256; v++) begin
            send(8'(v), ok_s);
            wait_valid(lat, saw, ok_v);
            checks++;
            if (!ok_s || !ok_v || lat != 3 || saw) begin
                errors++;
                $display("FAIL b2b_%0d_timing got lat=%0d ready_busy=%b exp 3 0", v, lat, saw);
            end
            checks++;
            if (io.out_bcd !== ref_bcd(v) || io.out_lz !== ref_lz(v)) begin
                errors++;
                $display("FAIL b2b_%0d_result got bcd=%h lz=%0d exp bcd=%h lz=%0d",
                         v, io.out_bcd, io.out_lz, ref_bcd(v), ref_lz(v));
            end
            held = ref_bcd(v);
            bad  = 0;
            xfer = 1'b0;
            for (int i = 0; i < 40 && !xfer; i++) begin
                io.out_ready = (i == 39) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk);
                if (io.out_ready) xfer = 1'b1;
                #1 io.out_ready = 1'b0;
                @(negedge clk);
                if (!xfer && (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.out_bcd !== held))
                    bad++;
            end
            checks++;
            if (bad != 0 || io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d_handshake got bad=%0d vld=%b rdy=%b exp 0 0 1",
                         v, bad, io.out_valid, io.in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
